// File: rtl/bomberman_pkg.sv
// Shared constants and types for the Bomberman VGA draw path.
// Contents: sprite id of the stage tiles, default stage geometry,
// draw-scan FSM state encoding and a minimum-one-bit width helper.
package bomberman_pkg;

  localparam int unsigned SPRITE_TILE  = 0;

  localparam int unsigned DEF_GRID_W   = 11;
  localparam int unsigned DEF_GRID_H   = 11;
  localparam int unsigned DEF_TILE_PX  = 16;
  localparam int unsigned DEF_ORIGIN_X = 72;
  localparam int unsigned DEF_ORIGIN_Y = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TILES   = 2'd1,
    PLAYERS = 2'd2,
    DONE    = 2'd3
  } draw_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/offset_counter.sv
// Two-dimensional modulo counter: x counts 0..X_COUNT-1 fastest, y
// advances when x wraps, and both wrap together after the last position.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   clear              : force both counts to zero on the next edge
//   en                 : advance one position on the next edge
//   x, y               : current position (registered)
//   next_x_c, next_y_c : position that will be loaded on the next edge
//   last_c             : current position is (X_COUNT-1, Y_COUNT-1)
module offset_counter #(
  parameter int unsigned X_COUNT = 16,
  parameter int unsigned Y_COUNT = 16,
  parameter int unsigned X_W     = 4,
  parameter int unsigned Y_W     = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] next_x_c,
  output logic [Y_W-1:0] next_y_c,
  output logic           last_c
);

  localparam logic [X_W-1:0] X_MAX = X_W'(X_COUNT - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(Y_COUNT - 1);

  // Next position; clear wins over enable.
  always_comb begin
    next_x_c = x;
    next_y_c = y;
    last_c   = (x == X_MAX) && (y == Y_MAX);
    if (clear) begin
      next_x_c = '0;
      next_y_c = '0;
    end else if (en) begin
      if (x == X_MAX) begin
        next_x_c = '0;
        next_y_c = (y == Y_MAX) ? '0 : y + Y_W'(1);
      end else begin
        next_x_c = x + X_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= next_x_c;
      y <= next_y_c;
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Frame-draw scanner: on start, walks every stage tile in row-major order
// and then every live player sprite, emitting one pixel per cycle.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : begin a frame (accepted only when idle)
//   stall         : downstream not ready, freezes the scan
//   player_xy     : per-player {Y, X} screen position, player 0 in the LSBs
//   player_alive  : per-player live mask
//   busy, done    : frame in progress / one-cycle end-of-frame pulse
//   pix_valid     : X_out/Y_out carry a pixel to draw
//   X_out, Y_out  : screen pixel
//   tile_index    : row*GRID_W+col during tiles, 0 during players
//   sprite_id     : 0 for tiles, i+1 for player i
//   px_offset     : {oy, ox} sprite-local offset
module sprite_draw_sequencer
  import bomberman_pkg::*;
#(
  parameter int unsigned GRID_W      = DEF_GRID_W,
  parameter int unsigned GRID_H      = DEF_GRID_H,
  parameter int unsigned TILE_PX     = DEF_TILE_PX,
  parameter int unsigned ORIGIN_X    = DEF_ORIGIN_X,
  parameter int unsigned ORIGIN_Y    = DEF_ORIGIN_Y,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned COORD_W     = 9,
  localparam int unsigned OFS_W      = width_of(TILE_PX),
  localparam int unsigned TILE_W     = width_of(GRID_W * GRID_H),
  localparam int unsigned SID_W      = width_of(NUM_PLAYERS + 1),
  localparam int unsigned XY_W       = NUM_PLAYERS * 2 * COORD_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic [XY_W-1:0]        player_xy,
  input  logic [NUM_PLAYERS-1:0] player_alive,
  output logic                   busy,
  output logic                   done,
  output logic                   pix_valid,
  output logic [COORD_W-1:0]     X_out,
  output logic [COORD_W-1:0]     Y_out,
  output logic [TILE_W-1:0]      tile_index,
  output logic [SID_W-1:0]       sprite_id,
  output logic [2*OFS_W-1:0]     px_offset
);

  localparam int unsigned COL_W = width_of(GRID_W);
  localparam int unsigned ROW_W = width_of(GRID_H);
  localparam int unsigned PL_W  = width_of(NUM_PLAYERS);
  localparam logic [PL_W-1:0] LAST_PLAYER = PL_W'(NUM_PLAYERS - 1);

  draw_state_t state, state_n;

  logic [PL_W-1:0]        player, player_n;
  logic [XY_W-1:0]        snap_xy;
  logic [NUM_PLAYERS-1:0] snap_alive;
  logic                   load_snap;

  logic             off_clr, off_en, off_last;
  logic [OFS_W-1:0] ox, oy, n_ox, n_oy;
  logic             tile_clr, tile_en, tile_last;
  logic [COL_W-1:0] col, n_col;
  logic [ROW_W-1:0] row, n_row;

  logic [NUM_PLAYERS-1:0] alive_sh, alive_sh_n;
  logic                   cur_alive, next_alive;
  logic [XY_W-1:0]        xy_sh;
  logic [COORD_W-1:0]     n_px, n_py;

  logic                   busy_n, done_n, pix_valid_n;
  logic [COORD_W-1:0]     x_n, y_n;
  logic [TILE_W-1:0]      tile_index_n;
  logic [SID_W-1:0]       sprite_id_n;
  logic [2*OFS_W-1:0]     px_offset_n;

  // In-sprite pixel offset.
  offset_counter #(
    .X_COUNT (TILE_PX),
    .Y_COUNT (TILE_PX),
    .X_W     (OFS_W),
    .Y_W     (OFS_W)
  ) u_offset (
    .clock    (clock),
    .reset    (reset),
    .clear    (off_clr),
    .en       (off_en),
    .x        (ox),
    .y        (oy),
    .next_x_c (n_ox),
    .next_y_c (n_oy),
    .last_c   (off_last)
  );

  // Stage tile position (col, row).
  offset_counter #(
    .X_COUNT (GRID_W),
    .Y_COUNT (GRID_H),
    .X_W     (COL_W),
    .Y_W     (ROW_W)
  ) u_tile (
    .clock    (clock),
    .reset    (reset),
    .clear    (tile_clr),
    .en       (tile_en),
    .x        (col),
    .y        (row),
    .next_x_c (n_col),
    .next_y_c (n_row),
    .last_c   (tile_last)
  );

  // Shifts avoid variable selects whose index width depends on NUM_PLAYERS.
  always_comb begin
    alive_sh   = snap_alive >> player;
    cur_alive  = alive_sh[0];
    alive_sh_n = snap_alive >> player_n;
    next_alive = alive_sh_n[0];
    xy_sh      = snap_xy >> (32'(player_n) * 2 * COORD_W);
    n_px       = xy_sh[COORD_W-1:0];
    n_py       = xy_sh[2*COORD_W-1:COORD_W];
  end

  // Next-state and counter control. Counters always hold the pixel that the
  // output registers currently show; a dead player holds for one skip cycle.
  always_comb begin
    state_n   = state;
    player_n  = player;
    load_snap = 1'b0;
    off_clr   = 1'b0;
    off_en    = 1'b0;
    tile_clr  = 1'b0;
    tile_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = TILES;
          player_n  = '0;
          load_snap = 1'b1;
          off_clr   = 1'b1;
          tile_clr  = 1'b1;
        end
      end
      TILES: begin
        if (!stall) begin
          off_en = 1'b1;
          if (off_last) begin
            if (tile_last) begin
              state_n  = PLAYERS;
              player_n = '0;
            end else begin
              tile_en = 1'b1;
            end
          end
        end
      end
      PLAYERS: begin
        if (!stall) begin
          off_en = cur_alive;
          if (!cur_alive || off_last) begin
            if (player == LAST_PLAYER) begin
              state_n = DONE;
            end else begin
              player_n = player + PL_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, taken from the next counter positions;
  // under stall those positions are unchanged so the outputs hold naturally.
  always_comb begin
    busy_n       = (state_n != IDLE);
    done_n       = (state_n == DONE);
    pix_valid_n  = 1'b0;
    x_n          = X_out;
    y_n          = Y_out;
    tile_index_n = tile_index;
    sprite_id_n  = sprite_id;
    px_offset_n  = px_offset;
    if (state_n == TILES) begin
      pix_valid_n  = 1'b1;
      x_n          = COORD_W'(ORIGIN_X) + COORD_W'({n_col, n_ox});
      y_n          = COORD_W'(ORIGIN_Y) + COORD_W'({n_row, n_oy});
      tile_index_n = TILE_W'(32'(n_row) * GRID_W + 32'(n_col));
      sprite_id_n  = SID_W'(SPRITE_TILE);
      px_offset_n  = {n_oy, n_ox};
    end else if (state_n == PLAYERS && next_alive) begin
      pix_valid_n  = 1'b1;
      x_n          = n_px + COORD_W'(n_ox);
      y_n          = n_py + COORD_W'(n_oy);
      tile_index_n = '0;
      sprite_id_n  = SID_W'(player_n) + SID_W'(1);
      px_offset_n  = {n_oy, n_ox};
    end
  end

  // State, player index, snapshots and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      player     <= '0;
      snap_xy    <= '0;
      snap_alive <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_valid  <= 1'b0;
      X_out      <= '0;
      Y_out      <= '0;
      tile_index <= '0;
      sprite_id  <= '0;
      px_offset  <= '0;
    end else begin
      state      <= state_n;
      player     <= player_n;
      if (load_snap) begin
        snap_xy    <= player_xy;
        snap_alive <= player_alive;
      end
      busy       <= busy_n;
      done       <= done_n;
      pix_valid  <= pix_valid_n;
      X_out      <= x_n;
      Y_out      <= y_n;
      tile_index <= tile_index_n;
      sprite_id  <= sprite_id_n;
      px_offset  <= px_offset_n;
    end
  end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Self-checking bench: two small instances (one and two players) on a 2x2
// grid of 2-pixel tiles, checked against a bench-built pixel scoreboard.
module tb_sprite_draw_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        sel   = 1'b0;
  logic [35:0] pxy   = '0;
  logic [1:0]  alive = '0;

  always #5 clock = ~clock;

  logic       busy1, done1, pv1, sid1;
  logic [8:0] x1, y1;
  logic [1:0] t1, off1;
  logic       busy2, done2, pv2;
  logic [8:0] x2, y2;
  logic [1:0] t2, sid2, off2;

  sprite_draw_sequencer #(
    .GRID_W(2), .GRID_H(2), .TILE_PX(2), .ORIGIN_X(10), .ORIGIN_Y(20),
    .NUM_PLAYERS(1), .COORD_W(9)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start & ~sel), .stall(stall & ~sel),
    .player_xy(pxy[17:0]), .player_alive(alive[0]),
    .busy(busy1), .done(done1), .pix_valid(pv1), .X_out(x1), .Y_out(y1),
    .tile_index(t1), .sprite_id(sid1), .px_offset(off1)
  );

  sprite_draw_sequencer #(
    .GRID_W(2), .GRID_H(2), .TILE_PX(2), .ORIGIN_X(10), .ORIGIN_Y(20),
    .NUM_PLAYERS(2), .COORD_W(9)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start & sel), .stall(stall & sel),
    .player_xy(pxy), .player_alive(alive),
    .busy(busy2), .done(done2), .pix_valid(pv2), .X_out(x2), .Y_out(y2),
    .tile_index(t2), .sprite_id(sid2), .px_offset(off2)
  );

  typedef struct packed {
    logic       v;
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] t;
    logic [1:0] sid;
    logic [1:0] off;
  } pix_t;

  logic busy_o, done_o;
  pix_t obs;
  assign busy_o = sel ? busy2 : busy1;
  assign done_o = sel ? done2 : done1;
  assign obs    = sel ? {pv2, x2, y2, t2, sid2, off2}
                      : {pv1, x1, y1, t1, 1'b0, sid1, off1};

  pix_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] lx[0:255];
  logic [8:0] ly[0:255];
  logic       lv[0:255];

  // Expected pixel stream for the currently selected instance and inputs.
  task automatic build_expected();
    pix_t e;
    int np;
    np = sel ? 2 : 1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int oy = 0; oy < 2; oy++)
          for (int ox = 0; ox < 2; ox++) begin
            e.v   = 1'b1;
            e.x   = 9'(10 + c * 2 + ox);
            e.y   = 9'(20 + r * 2 + oy);
            e.t   = 2'(r * 2 + c);
            e.sid = 2'd0;
            e.off = {1'(oy), 1'(ox)};
            q.push_back(e);
          end
    for (int i = 0; i < np; i++) begin
      if (alive[i]) begin
        for (int oy = 0; oy < 2; oy++)
          for (int ox = 0; ox < 2; ox++) begin
            e.v   = 1'b1;
            e.x   = pxy[i*18 +: 9] + 9'(ox);
            e.y   = pxy[i*18+9 +: 9] + 9'(oy);
            e.t   = 2'd0;
            e.sid = 2'(i + 1);
            e.off = {1'(oy), 1'(ox)};
            q.push_back(e);
          end
      end else begin
        e = '0;
        q.push_back(e);
      end
    end
  endtask

  // Pulse start, then score every cycle until done; optional stall window
  // and a mid-frame input change plus stray start at cycle poke_at.
  task automatic run_frame(input int stall_from, input int stall_len,
                           input int poke_at, output int done_cyc);
    pix_t e, last;
    logic prev_st;
    last     = '0;
    prev_st  = 1'b0;
    done_cyc = -1;
    build_expected();
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start = 1'b0;
      lx[c] = obs.x;
      ly[c] = obs.y;
      lv[c] = obs.v;
      if (prev_st) begin
        n_checks++;
        if (obs.v !== last.v || (last.v && obs !== last)) begin
          n_fail++;
          $display("FAIL stall_hold cycle %0d: got %h want %h", c, obs, last);
        end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        last = e;
        n_checks++;
        if (obs.v !== e.v || (e.v && obs !== e)) begin
          n_fail++;
          $display("FAIL pixel cycle %0d: got %h want %h", c, obs, e);
        end
      end else begin
        n_checks++;
        if (done_o !== 1'b1 || obs.v !== 1'b0) begin
          n_fail++;
          $display("FAIL done_pulse cycle %0d: done=%b pv=%b want 1/0", c, done_o, obs.v);
        end
        done_cyc = c;
      end
      if (done_cyc < 0) begin
        n_checks++;
        if (done_o !== 1'b0) begin
          n_fail++;
          $display("FAIL early_done cycle %0d: done=%b want 0", c, done_o);
        end
      end
      n_checks++;
      if (busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_high cycle %0d: busy=%b want 1", c, busy_o);
      end
      if (done_cyc >= 0) break;
      stall   = (c >= stall_from) && (c < stall_from + stall_len);
      prev_st = stall;
      if (c == poke_at) begin
        pxy   = ~pxy;
        start = 1'b1;
      end
    end
    stall = 1'b0;
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: no done within 200 cycles, %0d pixels left", q.size());
      q.delete();
    end
    @(negedge clock);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: busy=%b done=%b want 0/0", busy_o, done_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy1, done1, pv1, x1, y1, t1, sid1, off1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: got %h want 0", {busy1, done1, pv1, x1, y1, t1, sid1, off1});
    end
    n_checks++;
    if ({busy2, done2, pv2, x2, y2, t2, sid2, off2} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut2: got %h want 0", {busy2, done2, pv2, x2, y2, t2, sid2, off2});
    end
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (busy1 !== 1'b0 || pv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b pv=%b want 0/0", busy1, pv1);
    end
  endtask

  task automatic test_single_player();
    int d;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd50;
    pxy[17:9] = 9'd60;
    run_frame(0, 0, 0, d);
    n_checks++;
    if (d !== 21) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 21", d); end
    n_checks++;
    if (lx[1] !== 9'd10 || ly[1] !== 9'd20) begin
      n_fail++; $display("FAIL first_pixel: got (%0d,%0d) want (10,20)", lx[1], ly[1]);
    end
    n_checks++;
    if (lx[5] !== 9'd12 || ly[5] !== 9'd20) begin
      n_fail++; $display("FAIL fifth_pixel: got (%0d,%0d) want (12,20)", lx[5], ly[5]);
    end
    n_checks++;
    if (lx[17] !== 9'd50 || ly[17] !== 9'd60 || lx[20] !== 9'd51 || ly[20] !== 9'd61) begin
      n_fail++;
      $display("FAIL player_pixels: got (%0d,%0d)..(%0d,%0d) want (50,60)..(51,61)",
               lx[17], ly[17], lx[20], ly[20]);
    end
  endtask

  task automatic test_dead_player();
    int d;
    sel   = 1'b1;
    alive = 2'b10;
    pxy   = '0;
    pxy[8:0]   = 9'd200;
    pxy[17:9]  = 9'd201;
    pxy[26:18] = 9'd100;
    pxy[35:27] = 9'd30;
    run_frame(0, 0, 0, d);
    n_checks++;
    if (d !== 22) begin n_fail++; $display("FAIL dead_done_cycle: got %0d want 22", d); end
    n_checks++;
    if (lv[17] !== 1'b0 || lv[18] !== 1'b1 || lx[18] !== 9'd100) begin
      n_fail++;
      $display("FAIL dead_gap: pv17=%b pv18=%b x18=%0d want 0/1/100", lv[17], lv[18], lx[18]);
    end
    sel = 1'b0;
  endtask

  task automatic test_stall();
    int d;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd50;
    pxy[17:9] = 9'd60;
    run_frame(6, 3, 0, d);
    n_checks++;
    if (d !== 24) begin n_fail++; $display("FAIL stall_done_cycle: got %0d want 24", d); end
  endtask

  task automatic test_ignore_midframe();
    int d;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd70;
    pxy[17:9] = 9'd80;
    run_frame(0, 0, 5, d);
    n_checks++;
    if (d !== 21) begin n_fail++; $display("FAIL midframe_done_cycle: got %0d want 21", d); end
    pxy = '0;
  endtask

  task automatic test_reset_midframe();
    int d;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd50;
    pxy[17:9] = 9'd60;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({busy1, done1, pv1, x1, y1, t1, sid1, off1} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h want 0", {busy1, done1, pv1, x1, y1, t1, sid1, off1});
    end
    reset = 1'b0;
    run_frame(0, 0, 0, d);
    n_checks++;
    if (d !== 21 || lx[1] !== 9'd10 || ly[1] !== 9'd20) begin
      n_fail++;
      $display("FAIL restart_after_reset: done=%0d first=(%0d,%0d) want 21 (10,20)", d, lx[1], ly[1]);
    end
  endtask

  task automatic test_wrap();
    int d;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd511;
    pxy[17:9] = 9'd60;
    run_frame(0, 0, 0, d);
    n_checks++;
    if (lx[17] !== 9'd511 || lx[18] !== 9'd0) begin
      n_fail++; $display("FAIL x_wrap: got %0d,%0d want 511,0", lx[17], lx[18]);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    sel   = 1'b0;
    alive = 2'b01;
    pxy   = '0;
    pxy[8:0]  = 9'd5;
    pxy[17:9] = 9'd6;
    run_frame(0, 0, 0, d1);
    run_frame(0, 0, 0, d2);
    n_checks++;
    if (d1 !== 21 || d2 !== 21) begin
      n_fail++; $display("FAIL back_to_back: got %0d,%0d want 21,21", d1, d2);
    end
  endtask

  initial begin
    test_reset();
    test_single_player();
    test_dead_player();
    test_stall();
    test_ignore_midframe();
    test_reset_midframe();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
